// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Constants and types shared by the instruction-memory loader, its
//           stream front end and the instruction memory itself.
// Contents: INSTR_W, BYTES_PER_WORD, IMEM_SIZE_DEFAULT, loader_state_t,
//           is_pow2() helper for elaboration-time size checks.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int INSTR_W           = 32;
    localparam int BYTES_PER_WORD    = 4;
    localparam int IMEM_SIZE_DEFAULT = 1024;

    // Encoding order matters: it is the on-wire state code seen in debug.
    typedef enum logic [2:0] {
        LS_IDLE   = 3'd0,
        LS_HDR_HI = 3'd1,
        LS_HDR_LO = 3'd2,
        LS_DATA   = 3'd3,
        LS_WRITE  = 3'd4,
        LS_CKSUM  = 3'd5,
        LS_DONE   = 3'd6,
        LS_ERROR  = 3'd7
    } loader_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_if
// Purpose : Byte-stream input and instruction-RAM write bus of the loader.
// Signals : in_data/in_valid/in_ready - byte stream with valid/ready handshake
//           wr_en/wr_addr/wr_data     - one-cycle write strobe to the RAM
// Modports: slave  - the loader (consumes the stream, drives the RAM bus)
//           master - the environment (produces the stream, sees the writes)
// Revision: 1.0 - initial release
// ============================================================================
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = 64
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_word_packer
// Purpose : Packs an MSB-first byte stream into INSTR_W-bit words. The first
//           byte of each word ends up in the top byte lane.
// Ports   : clk, reset (async, active high)
//           clr        - synchronous clear of shift register and byte count
//           byte_valid - byte_in is consumed this cycle
//           byte_in    - stream byte
//           word       - shift register contents (a full word right after
//                        the edge that consumed its last byte)
//           word_valid - combinational: this cycle's byte completes a word
// Revision: 1.0 - initial release
// ============================================================================
module byte_word_packer
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BYTES_PER_WORD - 1);

    logic [INSTR_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (byte_valid) begin
            word_d = {word_q[INSTR_W-9:0], byte_in};
            // Counter wraps to zero after the last byte of a word.
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word       = word_q;
    assign word_valid = byte_valid && !clr && (cnt_q == c_last_byte);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Loads a program into the writable instruction RAM from a byte
//           stream. Stream format: 16-bit word count (high byte first), then
//           count x 4 instruction bytes, MSB first. Words go to consecutive
//           word-aligned byte addresses starting at 0. The CPU is held while
//           a load is running.
// Params  : MEM_SIZE - instruction memory size in bytes (power of two, > 4)
//           ADDR_W   - width of the RAM byte address (CPU PC width)
// Ports   : clk, reset (async, active high)
//           start        - begin a load (honoured in IDLE, DONE, ERROR)
//           busy         - load in progress
//           cpu_hold     - CPU stall request, equal to busy
//           done / error - sticky outcome of the last load
//           words_loaded - words written by the current / last load
//           bus          - byte stream in, RAM write bus out
// Options : IMEM_LOADER_CHECKSUM_EN - when defined, a trailing byte equal to
//           the XOR of all header and data bytes is required after the last
//           word; a mismatch ends the load in ERROR.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = IMEM_SIZE_DEFAULT,
    parameter int ADDR_W   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded,
    imem_loader_if.slave     bus
);

    generate
        if (!is_pow2(MEM_SIZE) || (MEM_SIZE <= BYTES_PER_WORD)) begin : g_bad_mem_size
            $error("imem_loader: MEM_SIZE must be a power of two greater than 4");
        end
    endgenerate

    localparam logic [2:0] c_st_idle   = LS_IDLE;
    localparam logic [2:0] c_st_hdr_hi = LS_HDR_HI;
    localparam logic [2:0] c_st_hdr_lo = LS_HDR_LO;
    localparam logic [2:0] c_st_data   = LS_DATA;
    localparam logic [2:0] c_st_write  = LS_WRITE;
    localparam logic [2:0] c_st_cksum  = LS_CKSUM;
    localparam logic [2:0] c_st_done   = LS_DONE;
    localparam logic [2:0] c_st_error  = LS_ERROR;

    // State entered once the last word (or an empty header) has been handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_st_finish = c_st_cksum;
`else
    localparam logic [2:0] c_st_finish = c_st_done;
`endif

    // Largest word count that still fits the memory.
    localparam int unsigned c_max_words = MEM_SIZE / BYTES_PER_WORD;

    logic [2:0]          state_q,   state_d;
    logic [15:0]         count_q,   count_d;
    logic [15:0]         words_q,   words_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0]  wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q,     xor_d;
`endif

    logic                in_ready;
    logic                accept;
    logic                wr_en;
    logic [15:0]         hdr_count;
    logic [ADDR_W-1:0]   cur_addr;
    logic                pk_clr;
    logic                pk_byte_valid;
    logic                pk_word_valid;
    logic [INSTR_W-1:0]  pk_word;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (pk_clr),
        .byte_valid (pk_byte_valid),
        .byte_in    (bus.in_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        in_ready = (state_q == c_st_hdr_hi) ||
                   (state_q == c_st_hdr_lo) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                   (state_q == c_st_cksum)  ||
`endif
                   (state_q == c_st_data);
    end

    assign accept        = bus.in_valid && in_ready;
    assign pk_byte_valid = accept && (state_q == c_st_data);
    assign wr_en         = (state_q == c_st_write);
    assign hdr_count     = {count_q[15:8], bus.in_data};
    // Word index times four: byte address is always word aligned.
    assign cur_addr      = ADDR_W'({words_q, 2'b00});

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pk_clr    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        if (accept && (state_q != c_st_cksum)) begin
            xor_d = xor_q ^ bus.in_data;
        end
`endif

        case (state_q)
            c_st_idle, c_st_done, c_st_error: begin
                if (start) begin
                    state_d = c_st_hdr_hi;
                    count_d = '0;
                    words_d = '0;
                    pk_clr  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end

            c_st_hdr_hi: begin
                if (accept) begin
                    count_d[15:8] = bus.in_data;
                    state_d       = c_st_hdr_lo;
                end
            end

            c_st_hdr_lo: begin
                if (accept) begin
                    count_d = hdr_count;
                    // Rejecting oversize loads here is what keeps every
                    // later write address inside the memory.
                    if (32'(hdr_count) > c_max_words) begin
                        state_d = c_st_error;
                    end else if (hdr_count == 16'd0) begin
                        state_d = c_st_finish;
                    end else begin
                        state_d = c_st_data;
                    end
                end
            end

            c_st_data: begin
                if (pk_word_valid) begin
                    state_d = c_st_write;
                end
            end

            c_st_write: begin
                words_d   = words_q + 16'd1;
                wr_addr_d = cur_addr;
                wr_data_d = pk_word;
                if ((words_q + 16'd1) == count_q) begin
                    state_d = c_st_finish;
                end else begin
                    state_d = c_st_data;
                end
            end

            c_st_cksum: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (bus.in_data == xor_q) ? c_st_done : c_st_error;
                end
`else
                state_d = c_st_idle;
`endif
            end

            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_st_idle;
            count_q   <= '0;
            words_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            words_q   <= words_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    // The live word is presented during the strobe; afterwards the captured
    // copies keep the bus stable while the packer fills the next word.
    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_en ? cur_addr : wr_addr_q;
    assign bus.wr_data   = wr_en ? pk_word  : wr_data_q;

    assign busy          = (state_q != c_st_idle) &&
                           (state_q != c_st_done) &&
                           (state_q != c_st_error);
    assign cpu_hold      = busy;
    assign done          = (state_q == c_st_done);
    assign error         = (state_q == c_st_error);
    assign words_loaded  = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Self-checking bench for imem_loader. Expected RAM writes are
//           queued when a stream is driven and compared when wr_en fires.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int MEM_SIZE = 1024;
    localparam int ADDR_W   = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .start        (start),
        .busy         (busy),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  stim[$];
    int          n_vec       = 0;
    int          n_err       = 0;
    int          cyc         = 0;
    int          last_wr_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            check("ready_during_write", 64'(bus.in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.wr_en), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, mon_e.addr);
                check("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            end
            last_wr_cyc = cyc;
        end
    end

    // Offers one byte until accepted; optional random idle cycles.
    task automatic send_byte(input logic [7:0] b, input bit stress);
        bit sent = 1'b0;
        for (int g = 0; g < 200 && !sent; g++) begin
            if (stress && ($urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
            end
            @(negedge clk);
            sent = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        check("byte_accepted", 64'(sent), 64'd1);
    endtask

    task automatic run_load(input logic [7:0] s[$], input bit stress, input bit bad_ck,
                            input string name);
        logic [15:0] cnt;
        bit          over;
        bit          exp_err;
        int          nfull;
        logic [7:0]  x;
        bit          fell;
        int          fall;

        cnt  = {s[0], s[1]};
        over = (int'(cnt) * 4) > MEM_SIZE;
        x    = 8'h00;
        foreach (s[i]) x ^= s[i];
        if (!over) begin
            nfull = (s.size() - 2) / 4;
            if (nfull > int'(cnt)) nfull = int'(cnt);
            for (int w = 0; w < nfull; w++) begin
                exp_q.push_back('{64'(w * 4),
                                  {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]}});
            end
            if (CK_EN) s.push_back(bad_ck ? ~x : x);
        end
        exp_err = over || (CK_EN && bad_ck);

        @(posedge clk);
        #1;
        start = 1'b1;
        check({name, "_busy_before_start"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        // In the stress run start stays high to show it is ignored while busy.
        start = stress;
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        foreach (s[i]) send_byte(s[i], stress);
        start = 1'b0;

        fell = 1'b0;
        fall = 0;
        for (int g = 0; g < 64 && !fell; g++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1'b1;
                fall = cyc;
            end
        end
        check({name, "_went_idle"},  64'(fell),         64'd1);
        check({name, "_done"},       64'(done),         64'(!exp_err));
        check({name, "_error"},      64'(error),        64'(exp_err));
        check({name, "_words"},      64'(words_loaded), over ? 64'd0 : 64'(cnt));
        check({name, "_cpu_hold"},   64'(cpu_hold),     64'd0);
        check({name, "_ready_idle"}, 64'(bus.in_ready), 64'd0);
        check({name, "_sb_empty"},   64'(exp_q.size()), 64'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (!over && (cnt != 16'd0)) begin
            check({name, "_busy_fall_cycle"}, 64'(fall), 64'(last_wr_cyc + 1));
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_done",     64'(done),         64'd0);
        check("rst_error",    64'(error),        64'd0);
        check("rst_words",    64'(words_loaded), 64'd0);
        check("rst_ready",    64'(bus.in_ready), 64'd0);
        check("rst_wr_en",    64'(bus.wr_en),    64'd0);
        check("rst_wr_addr",  bus.wr_addr,       64'd0);
        check("rst_wr_data",  64'(bus.wr_data),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal two-word load.
        stim = '{8'h00, 8'h02, 8'h91, 8'h00, 8'h04, 8'h1F, 8'hD2, 8'h80, 8'h00, 8'h20};
        run_load(stim, 1'b0, 1'b0, "nominal");
        check("hold_wr_addr", bus.wr_addr,      64'h4);
        check("hold_wr_data", 64'(bus.wr_data), 64'hD280_0020);

        // Same stream with random idle cycles and start held high.
        run_load(stim, 1'b1, 1'b0, "backpressure");

        // Oversize header: 257 words do not fit 1024 bytes.
        stim = '{8'h01, 8'h01};
        run_load(stim, 1'b0, 1'b0, "oversize");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("oversize_ready_after", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        check("oversize_still_error", 64'(error), 64'd1);

        // Empty load.
        stim = '{8'h00, 8'h00};
        run_load(stim, 1'b0, 1'b0, "empty");

        // Reset in the middle of the second word.
        stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
        exp_q.push_back('{64'd0, 32'hDEAD_BEEF});
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        foreach (stim[i]) send_byte(stim[i], 1'b0);
        check("midload_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",     64'(busy),         64'd0);
        check("arst_cpu_hold", 64'(cpu_hold),     64'd0);
        check("arst_done",     64'(done),         64'd0);
        check("arst_error",    64'(error),        64'd0);
        check("arst_words",    64'(words_loaded), 64'd0);
        check("arst_ready",    64'(bus.in_ready), 64'd0);
        check("arst_wr_addr",  bus.wr_addr,       64'd0);
        check("arst_wr_data",  64'(bus.wr_data),  64'd0);
        check("arst_sb_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stim = '{8'h00, 8'h01, 8'h13, 8'h57, 8'h24, 8'h68};
        run_load(stim, 1'b0, 1'b0, "after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(stim, 1'b0, 1'b0, "cksum_good");
        run_load(stim, 1'b0, 1'b1, "cksum_bad");
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
